sec_scrub_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared 32-bit single-error-correcting (SEC) corrector on the protected-memory read path. It shares one memory read port and one combinational SEC corrector between host read requests and a background scrubber that walks every address. It writes back corrected words, returns host responses with an error flag, and counts corrections. It sits between the host load interface, the 40-bit (32 data + 8 check) memory macro and the corrector.

---
 rtl/sec_scrub_ctrl_pkg.sv | 21 ++
 rtl/sec_scrub_ctrl_if.sv | 24 ++
 rtl/sec_scrub_ctrl_timer.sv | 32 +++
 rtl/sec_scrub_ctrl.sv | 143 ++++++++++++++
 tb/tb_sec_scrub_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sec_scrub_ctrl_pkg.sv
// Shared types and widths for the SEC scrub/read controller.
package sec_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    DONE,
    WB
  } state_t;

  typedef enum logic {
    HOST,
    SCRUB
  } owner_t;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/sec_scrub_ctrl_if.sv
// Host load interface: request handshake plus one-cycle response pulse.
interface sec_scrub_ctrl_if #(
  parameter int ADDR_W = 10
);
  import sec_ctrl_pkg::*;

  logic              host_req_valid;
  logic [ADDR_W-1:0] host_req_addr;
  logic              host_req_ready;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_data;
  logic              host_rsp_err;

  modport master (
    output host_req_valid, host_req_addr,
    input  host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err
  );

  modport slave (
    input  host_req_valid, host_req_addr,
    output host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err
  );

endinterface

// File: rtl/sec_scrub_ctrl_timer.sv
// Scrub interval timer: raises a single pending flag every SCRUB_INTERVAL
// enabled cycles; a request arriving while one is pending is dropped.
module sec_scrub_timer #(
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_en,
  input  logic clr,
  output logic scrub_pend
);
  localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(SCRUB_INTERVAL - 1);

  logic [TW-1:0] cnt;

  // Interval counter and pending flag; a grant clear wins over a new tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      scrub_pend <= 1'b0;
    end else begin
      if (set_en) begin
        if (cnt == LAST) cnt <= '0;
        else             cnt <= cnt + TW'(1);
      end
      if (clr)                          scrub_pend <= 1'b0;
      else if (set_en && (cnt == LAST)) scrub_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/sec_scrub_ctrl.sv
// Arbitrates one memory read port and one external SEC corrector between
// host reads and a background scrubber; writes back corrected scrub words
// and keeps a saturating correction count.
module sec_scrub_ctrl
  import sec_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STARVE_MAX     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_ecc_en,
  input  logic                    cfg_scrub_en,
  sec_scrub_ctrl_if.slave         host,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W+CHK_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0]       mem_wr_data,
  output logic [DATA_W-1:0]       sec_data_in,
  output logic [CHK_W-1:0]        sec_chk_in,
  output logic                    sec_en,
  input  logic [DATA_W-1:0]       sec_data_out,
  output logic [ADDR_W-1:0]       scrub_addr,
  output logic                    scrub_wrap,
  output logic [CNT_W-1:0]        corr_cnt
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t            state;
  owner_t            owner;
  logic              ecc_q;
  logic              corr_q;
  logic [DATA_W-1:0] cap_data;
  logic [SW-1:0]     starve_cnt;
  logic              scrub_pend;
  logic              scrub_win;
  logic              host_win;
  logic              in_capt;
  logic              corr_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sec_scrub_timer #(
    .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (cfg_scrub_en),
    .clr       (scrub_win),
    .scrub_pend(scrub_pend)
  );

  // Scrub takes the port when the host is quiet or has used its starvation budget.
  assign scrub_win = (state == IDLE) && scrub_pend &&
                     (!host.host_req_valid || (starve_cnt == STARVE_LIM));
  assign host_win  = (state == IDLE) && host.host_req_valid && !scrub_win;
  assign host.host_req_ready = host_win;

  // The corrector only sees traffic in CAPT, when memory data is valid.
  assign in_capt     = (state == CAPT);
  assign sec_en      = in_capt && ecc_q;
  assign sec_data_in = in_capt ? mem_rd_data[DATA_W-1:0] : '0;
  assign sec_chk_in  = in_capt ? mem_rd_data[DATA_W+CHK_W-1:DATA_W] : '0;
  assign corr_now    = in_capt && ecc_q && (sec_data_out != mem_rd_data[DATA_W-1:0]);

  // Transaction FSM; every strobe is registered on the edge entering its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      owner               <= HOST;
      ecc_q               <= 1'b0;
      corr_q              <= 1'b0;
      cap_data            <= '0;
      starve_cnt          <= '0;
      mem_rd_en           <= 1'b0;
      mem_wr_en           <= 1'b0;
      mem_addr            <= '0;
      mem_wr_data         <= '0;
      host.host_rsp_valid <= 1'b0;
      host.host_rsp_data  <= '0;
      host.host_rsp_err   <= 1'b0;
      scrub_addr          <= '0;
      scrub_wrap          <= 1'b0;
      corr_cnt            <= '0;
    end else begin
      mem_rd_en           <= 1'b0;
      mem_wr_en           <= 1'b0;
      host.host_rsp_valid <= 1'b0;
      scrub_wrap          <= 1'b0;
      case (state)
        IDLE: begin
          if (scrub_win) begin
            owner      <= SCRUB;
            mem_addr   <= scrub_addr;
            ecc_q      <= cfg_ecc_en;
            starve_cnt <= '0;
            mem_rd_en  <= 1'b1;
            state      <= ISSUE;
          end else if (host_win) begin
            owner     <= HOST;
            mem_addr  <= host.host_req_addr;
            ecc_q     <= cfg_ecc_en;
            mem_rd_en <= 1'b1;
            if (scrub_pend) starve_cnt <= starve_cnt + SW'(1);
            state     <= ISSUE;
          end
        end
        ISSUE: state <= CAPT;
        CAPT: begin
          cap_data <= sec_data_out;
          corr_q   <= corr_now;
          if (corr_now) corr_cnt <= sat_inc(corr_cnt);
          if (owner == HOST) begin
            host.host_rsp_valid <= 1'b1;
            host.host_rsp_data  <= sec_data_out;
            host.host_rsp_err   <= corr_now;
          end else begin
            scrub_addr <= scrub_addr + ADDR_W'(1);
            scrub_wrap <= &scrub_addr;
          end
          state <= DONE;
        end
        DONE: begin
          if ((owner == SCRUB) && corr_q) begin
            mem_wr_en   <= 1'b1;
            mem_wr_data <= cap_data;
            state       <= WB;
          end else begin
            state <= IDLE;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// Bench for sec_scrub_ctrl: memory and corrector models, scoreboarded host
// responses and scrub writebacks, one task per scenario.
module tb_sec_scrub_ctrl;
  localparam int AW = 3;

  typedef struct packed { logic [31:0] d; logic e; } rsp_t;
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_ecc_en = 1'b0;
  logic cfg_scrub_en = 1'b0;
  logic mem_rd_en, mem_wr_en, sec_en, scrub_wrap;
  logic [AW-1:0] mem_addr, scrub_addr;
  logic [39:0] mem_rd_data;
  logic [31:0] mem_wr_data, sec_data_in, sec_data_out;
  logic [7:0] sec_chk_in;
  logic [15:0] corr_cnt;

  logic [39:0] mem [0:7];
  logic tb_wr = 1'b0;
  logic [AW-1:0] tb_wr_addr = '0;
  logic [39:0] tb_wr_val = '0;

  int tests = 0;
  int fails = 0;
  rsp_t rsp_q[$];
  wb_t wb_q[$];

  always #5 clk = ~clk;

  sec_scrub_ctrl_if #(.ADDR_W(AW)) hif ();

  sec_scrub_ctrl #(.ADDR_W(AW), .SCRUB_INTERVAL(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_ecc_en(cfg_ecc_en), .cfg_scrub_en(cfg_scrub_en),
    .host(hif.slave), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data), .sec_data_in(sec_data_in),
    .sec_chk_in(sec_chk_in), .sec_en(sec_en), .sec_data_out(sec_data_out),
    .scrub_addr(scrub_addr), .scrub_wrap(scrub_wrap), .corr_cnt(corr_cnt)
  );

  // Memory macro: one-cycle read latency, writeback re-encodes as clean.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= {8'h00, mem_wr_data};
    if (tb_wr) mem[tb_wr_addr] <= tb_wr_val;
  end

  // Corrector stub: chk[7] marks a single-bit error at position chk[4:0].
  assign sec_data_out = (sec_en && sec_chk_in[7]) ?
                        (sec_data_in ^ (32'h1 << sec_chk_in[4:0])) : sec_data_in;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [AW-1:0] a, input logic [39:0] v);
    @(negedge clk);
    tb_wr = 1'b1; tb_wr_addr = a; tb_wr_val = v;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic host_txn(input logic [AW-1:0] a, output int lat, output logic rd1,
                          output logic [AW-1:0] addr1, output logic sec1, output logic sec2,
                          output logic [31:0] sdin2, output logic [31:0] d, output logic e,
                          output logic wr_seen, output logic to);
    int n;
    to = 1'b0; wr_seen = 1'b0; rd1 = 1'b0; addr1 = '0; sec1 = 1'b0; sec2 = 1'b0;
    sdin2 = '0; d = '0; e = 1'b0; lat = 0;
    @(negedge clk);
    hif.host_req_valid = 1'b1; hif.host_req_addr = a;
    #1;
    n = 0;
    while (!hif.host_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!hif.host_req_ready) begin to = 1'b1; hif.host_req_valid = 1'b0; return; end
    @(negedge clk);
    hif.host_req_valid = 1'b0;
    lat = 1; rd1 = mem_rd_en; addr1 = mem_addr; sec1 = sec_en;
    while (!hif.host_rsp_valid && lat < 10) begin
      if (mem_wr_en) wr_seen = 1'b1;
      @(negedge clk); lat++;
      if (lat == 2) begin sec2 = sec_en; sdin2 = sec_data_in; end
    end
    if (!hif.host_rsp_valid) to = 1'b1;
    d = hif.host_rsp_data; e = hif.host_rsp_err;
    repeat (3) begin @(negedge clk); if (mem_wr_en) wr_seen = 1'b1; end
  endtask

  task automatic test_reset();
    hif.host_req_valid = 1'b0; hif.host_req_addr = '0;
    for (int i = 0; i < 8; i++) poke(AW'(i), {8'h00, 32'hA5A50000 | i});
    @(negedge clk);
    tests++; if ({mem_rd_en, mem_wr_en, hif.host_rsp_valid, hif.host_rsp_err, scrub_wrap, sec_en} !== 6'b0)
      begin fails++; $display("FAIL reset_strobes got %b want 0", {mem_rd_en, mem_wr_en, hif.host_rsp_valid, hif.host_rsp_err, scrub_wrap, sec_en}); end
    tests++; if (hif.host_rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", hif.host_rsp_data); end
    tests++; if ({scrub_addr, corr_cnt, sec_data_in, sec_chk_in} !== '0)
      begin fails++; $display("FAIL reset_regs got %h/%h/%h/%h want 0", scrub_addr, corr_cnt, sec_data_in, sec_chk_in); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({hif.host_req_ready, mem_rd_en} !== 2'b00) begin fails++; $display("FAIL idle_quiet got %b want 00", {hif.host_req_ready, mem_rd_en}); end
  endtask

  task automatic test_host_clean();
    int lat; logic rd1, sec1, sec2, e, wr, to; logic [AW-1:0] a1; logic [31:0] sd, d; rsp_t x;
    cfg_ecc_en = 1'b1;
    poke(3'd5, {8'h00, 32'hDEADBEEF});
    rsp_q.push_back('{d: 32'hDEADBEEF, e: 1'b0});
    host_txn(3'd5, lat, rd1, a1, sec1, sec2, sd, d, e, wr, to);
    x = rsp_q.pop_front();
    tests++; if (to) begin fails++; $display("FAIL clean_timeout got timeout want response"); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL clean_latency got %0d want 3", lat); end
    tests++; if ({rd1, a1, sec1} !== {1'b1, 3'd5, 1'b0}) begin fails++; $display("FAIL clean_issue got rd=%b addr=%0d sec=%b want 1/5/0", rd1, a1, sec1); end
    tests++; if ({sec2, sd} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL clean_capt got en=%b data=%h want 1/deadbeef", sec2, sd); end
    tests++; if ({d, e} !== {x.d, x.e}) begin fails++; $display("FAIL clean_rsp got %h/%b want %h/%b", d, e, x.d, x.e); end
    tests++; if ({wr, corr_cnt} !== {1'b0, 16'd0}) begin fails++; $display("FAIL clean_cnt got wr=%b cnt=%0d want 0/0", wr, corr_cnt); end
  endtask

  task automatic test_host_corr();
    int lat; logic rd1, sec1, sec2, e, wr, to; logic [AW-1:0] a1; logic [31:0] sd, d; rsp_t x;
    poke(3'd6, {8'h83, 32'hDEADBEE7});
    rsp_q.push_back('{d: 32'hDEADBEEF, e: 1'b1});
    host_txn(3'd6, lat, rd1, a1, sec1, sec2, sd, d, e, wr, to);
    x = rsp_q.pop_front();
    tests++; if (to) begin fails++; $display("FAIL corr_timeout got timeout want response"); end
    tests++; if ({d, e} !== {x.d, x.e}) begin fails++; $display("FAIL corr_rsp got %h/%b want %h/%b", d, e, x.d, x.e); end
    tests++; if ({wr, corr_cnt} !== {1'b0, 16'd1}) begin fails++; $display("FAIL corr_cnt got wr=%b cnt=%0d want 0/1", wr, corr_cnt); end
  endtask

  task automatic test_ecc_off();
    int lat; logic rd1, sec1, sec2, e, wr, to; logic [AW-1:0] a1; logic [31:0] sd, d; rsp_t x;
    cfg_ecc_en = 1'b0;
    rsp_q.push_back('{d: 32'hDEADBEE7, e: 1'b0});
    host_txn(3'd6, lat, rd1, a1, sec1, sec2, sd, d, e, wr, to);
    x = rsp_q.pop_front();
    cfg_ecc_en = 1'b1;
    tests++; if ({to, sec2} !== 2'b00) begin fails++; $display("FAIL eccoff_ctrl got to=%b sec_en=%b want 0/0", to, sec2); end
    tests++; if ({d, e} !== {x.d, x.e}) begin fails++; $display("FAIL eccoff_rsp got %h/%b want %h/%b", d, e, x.d, x.e); end
    tests++; if (corr_cnt !== 16'd1) begin fails++; $display("FAIL eccoff_cnt got %0d want 1", corr_cnt); end
  endtask

  task automatic test_scrub_wb();
    int n, rd_at; logic found; wb_t x;
    poke(3'd0, {8'h85, 32'h12345678 ^ 32'h20});
    wb_q.push_back('{a: 3'd0, d: 32'h12345678});
    cfg_scrub_en = 1'b1;
    n = 0; rd_at = -100; found = 1'b0;
    while (!found && n < 60) begin
      @(negedge clk); n++;
      if (mem_rd_en) rd_at = n;
      if (mem_wr_en) found = 1'b1;
    end
    cfg_scrub_en = 1'b0;
    x = wb_q.pop_front();
    tests++; if (!found) begin fails++; $display("FAIL wb_timeout got no mem_wr_en want writeback"); end
    tests++; if ({mem_addr, mem_wr_data} !== {x.a, x.d}) begin fails++; $display("FAIL wb_data got %0d/%h want %0d/%h", mem_addr, mem_wr_data, x.a, x.d); end
    tests++; if (n - rd_at !== 3) begin fails++; $display("FAIL wb_timing got %0d want 3", n - rd_at); end
    @(negedge clk);
    tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL wb_pulse got %b want 0", mem_wr_en); end
    repeat (4) @(negedge clk);
    tests++; if ({scrub_addr, corr_cnt} !== {3'd1, 16'd2}) begin fails++; $display("FAIL wb_after got addr=%0d cnt=%0d want 1/2", scrub_addr, corr_cnt); end
    tests++; if (mem[0] !== {8'h00, 32'h12345678}) begin fails++; $display("FAIL wb_mem got %h want 0012345678", mem[0]); end
  endtask

  task automatic test_starve();
    logic q[$]; int n; logic prev_rdy, seen, exp_s;
    for (int i = 0; i < 4; i++) q.push_back(1'b0);
    q.push_back(1'b1); q.push_back(1'b0);
    cfg_scrub_en = 1'b1;
    @(negedge clk);
    hif.host_req_valid = 1'b1; hif.host_req_addr = 3'd2;
    prev_rdy = 1'b0; seen = 1'b0; n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk); n++;
      if (!seen && dut.scrub_pend) begin seen = 1'b1; cfg_scrub_en = 1'b0; end
      if (seen && mem_rd_en && !prev_rdy) begin
        exp_s = q.pop_front();
        tests++; if (exp_s !== 1'b1) begin fails++; $display("FAIL starve_grant got SCRUB want HOST"); end
      end
      if (seen && hif.host_req_ready && q.size() > 0) begin
        exp_s = q.pop_front();
        tests++; if (exp_s !== 1'b0) begin fails++; $display("FAIL starve_grant got HOST want SCRUB"); end
      end
      prev_rdy = hif.host_req_ready;
    end
    cfg_scrub_en = 1'b0;
    @(negedge clk);
    hif.host_req_valid = 1'b0;
    tests++; if (q.size() != 0) begin fails++; $display("FAIL starve_timeout got %0d grants left want 0", q.size()); end
    repeat (8) @(negedge clk);
    tests++; if ({scrub_addr, corr_cnt} !== {3'd2, 16'd2}) begin fails++; $display("FAIL starve_after got addr=%0d cnt=%0d want 2/2", scrub_addr, corr_cnt); end
  endtask

  task automatic test_scrub_wrap();
    int n, scrubs, wraps; logic [AW-1:0] addr_at_wrap;
    cfg_scrub_en = 1'b1;
    n = 0; scrubs = 0; wraps = 0; addr_at_wrap = '1;
    while (wraps == 0 && n < 300) begin
      @(negedge clk); n++;
      if (mem_rd_en) scrubs++;
      if (scrub_wrap) begin wraps++; addr_at_wrap = scrub_addr; end
    end
    cfg_scrub_en = 1'b0;
    tests++; if (scrubs !== 6) begin fails++; $display("FAIL wrap_scrubs got %0d want 6", scrubs); end
    tests++; if (addr_at_wrap !== 3'd0) begin fails++; $display("FAIL wrap_addr got %0d want 0", addr_at_wrap); end
    repeat (20) begin @(negedge clk); if (scrub_wrap) wraps++; end
    tests++; if (wraps !== 1) begin fails++; $display("FAIL wrap_count got %0d want 1", wraps); end
  endtask

  task automatic test_reset_mid();
    int n, late; logic to;
    int lat; logic rd1, sec1, sec2, e, wr; logic [AW-1:0] a1; logic [31:0] sd, d; rsp_t x;
    repeat (12) @(negedge clk);
    @(negedge clk);
    hif.host_req_valid = 1'b1; hif.host_req_addr = 3'd4;
    #1;
    n = 0;
    while (!hif.host_req_ready && n < 50) begin @(negedge clk); n++; end
    to = !hif.host_req_ready;
    @(negedge clk);
    hif.host_req_valid = 1'b0;
    @(negedge clk);
    tests++; if ({to, sec_en} !== 2'b01) begin fails++; $display("FAIL rstmid_capt got to=%b sec_en=%b want 0/1", to, sec_en); end
    rst_n = 1'b0;
    #1;
    tests++; if ({mem_rd_en, mem_wr_en, hif.host_rsp_valid, hif.host_rsp_err, scrub_wrap, sec_en, hif.host_req_ready} !== 7'b0)
      begin fails++; $display("FAIL rstmid_strobes got %b want 0", {mem_rd_en, mem_wr_en, hif.host_rsp_valid, hif.host_rsp_err, scrub_wrap, sec_en, hif.host_req_ready}); end
    tests++; if ({hif.host_rsp_data, sec_data_in, sec_chk_in, corr_cnt, scrub_addr, mem_addr, mem_wr_data} !== '0)
      begin fails++; $display("FAIL rstmid_regs got %h/%h/%h/%h/%h/%h want 0", hif.host_rsp_data, sec_data_in, corr_cnt, scrub_addr, mem_addr, mem_wr_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    repeat (8) begin @(negedge clk); if (hif.host_rsp_valid || mem_wr_en) late++; end
    tests++; if (late !== 0) begin fails++; $display("FAIL rstmid_stale got %0d pulses want 0", late); end
    rsp_q.push_back('{d: 32'hA5A50004, e: 1'b0});
    host_txn(3'd4, lat, rd1, a1, sec1, sec2, sd, d, e, wr, to);
    x = rsp_q.pop_front();
    tests++; if ({to, lat} !== {1'b0, 32'sd3}) begin fails++; $display("FAIL rstmid_next_lat got to=%b lat=%0d want 0/3", to, lat); end
    tests++; if ({d, e} !== {x.d, x.e}) begin fails++; $display("FAIL rstmid_next_rsp got %h/%b want %h/%b", d, e, x.d, x.e); end
  endtask

  initial begin
    test_reset();
    test_host_clean();
    test_host_corr();
    test_ecc_off();
    test_scrub_wb();
    test_starve();
    test_scrub_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
